etx_serializer: RTL and testbench

//  Transmit-side byte serializer for the elink: the counterpart of the receive

---
 rtl/etx_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_etx_serializer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : etx_serializer
// Purpose  : Transmit-side byte serializer for the elink. Takes one emesh
//            packet at a time on a valid/wait handshake. Sends it on the
//            8-bit tx_frame/tx_data link stream, one byte per clk.
//            Sequential 32-bit writes are chained into a single burst frame.
// Ports    : clk         - single clock
//            reset       - synchronous reset, active high
//            tx_access   - packet valid
//            tx_packet   - emesh packet (PW bits)
//            tx_wait     - pushback to the source (combinational)
//            tx_wr_wait  - remote write pushback (synchronous to clk)
//            tx_rd_wait  - remote read pushback (synchronous to clk)
//            tx_frame    - frame qualifier (registered)
//            tx_data     - link byte (registered)
//            tx_busy     - high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module etx_serializer #(
  parameter int PW       = 104,
  parameter int MAXBURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tx_access,
  input  logic [PW-1:0] tx_packet,
  output logic          tx_wait,
  input  logic          tx_wr_wait,
  input  logic          tx_rd_wait,
  output logic          tx_frame,
  output logic [7:0]    tx_data,
  output logic          tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DST  = 3'd2,
    S_DATA = 3'd3,
    S_SRC  = 3'd4
  } state_t;

  localparam logic [7:0] c_burst_lim = 8'(MAXBURST - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_nxt;
  logic [PW-1:0] r_pkt;
  logic [PW-1:0] w_pkt_nxt;
  logic [7:0]    r_burst_cnt;
  logic [7:0]    w_burst_cnt_nxt;
  logic          r_frame;
  logic [7:0]    r_data;
  logic [7:0]    w_byte_nxt;
  logic          w_wait;
  logic          w_accept;
  logic          w_chain_ok;

  // Field views of the held packet and of the incoming packet
  logic          w_cur_write;
  logic [1:0]    w_cur_dm;
  logic [3:0]    w_cur_ctrl;
  logic [31:0]   w_cur_dst;
  logic          w_in_write;
  logic [1:0]    w_in_dm;
  logic [3:0]    w_in_ctrl;
  logic [31:0]   w_in_dst;
  logic [31:0]   w_dst_inc;

  assign w_cur_write = r_pkt[0];
  assign w_cur_dm    = r_pkt[2:1];
  assign w_cur_ctrl  = r_pkt[7:4];
  assign w_cur_dst   = r_pkt[39:8];
  assign w_in_write  = tx_packet[0];
  assign w_in_dm     = tx_packet[2:1];
  assign w_in_ctrl   = tx_packet[7:4];
  assign w_in_dst    = tx_packet[39:8];

  // 32-bit add wraps naturally, so 0xFFFFFFFC is followed by 0x00000000
  assign w_dst_inc   = w_cur_dst + 32'd4;

  assign w_chain_ok  = w_cur_write & w_in_write
                     & (w_cur_dm == 2'b10) & (w_in_dm == 2'b10)
                     & (w_cur_ctrl == w_in_ctrl)
                     & (w_in_dst == w_dst_inc)
                     & ~tx_wr_wait
                     & (r_burst_cnt < c_burst_lim);

  // Pushback: only IDLE and the last data byte can take a new packet.
  always_comb begin
    w_wait = 1'b1;
    case (r_state)
      S_IDLE: w_wait = tx_access & (w_in_write ? tx_wr_wait : tx_rd_wait);
      S_DATA: w_wait = (r_idx == 2'd3) ? ~w_chain_ok : 1'b1;
      default: w_wait = 1'b1;
    endcase
  end

  assign w_accept = tx_access & ~w_wait;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pkt_nxt       = r_pkt;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = 2'd0;
        if (w_accept) begin
          w_state_nxt     = S_HDR;
          w_pkt_nxt       = tx_packet;
          w_burst_cnt_nxt = 8'd0;
        end
      end
      S_HDR: begin
        w_state_nxt = S_DST;
        w_idx_nxt   = 2'd0;
      end
      S_DST: begin
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          if (w_accept) begin
            // Chained write: skip header and address, go straight to data
            w_state_nxt     = S_DATA;
            w_pkt_nxt       = tx_packet;
            w_burst_cnt_nxt = r_burst_cnt + 8'd1;
          end else if (w_cur_write) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SRC;
          end
        end
      end
      S_SRC: begin
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Output byte is derived from the next state so the registered output
  // lines up with the state it belongs to (header appears one cycle after accept).
  always_comb begin
    w_byte_nxt = 8'h00;
    case (w_state_nxt)
      S_HDR:   w_byte_nxt = {w_pkt_nxt[7:4], w_pkt_nxt[2:1], w_pkt_nxt[0], 1'b0};
      S_DST:   w_byte_nxt = sel_byte(w_pkt_nxt[39:8], w_idx_nxt);
      S_DATA:  w_byte_nxt = sel_byte(w_pkt_nxt[71:40], w_idx_nxt);
      S_SRC:   w_byte_nxt = sel_byte(w_pkt_nxt[103:72], w_idx_nxt);
      default: w_byte_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_pkt       <= '0;
      r_burst_cnt <= 8'd0;
      r_frame     <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pkt       <= w_pkt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_frame     <= (w_state_nxt != S_IDLE);
      r_data      <= w_byte_nxt;
    end
  end

  assign tx_wait  = w_wait;
  assign tx_frame = r_frame;
  assign tx_data  = r_data;
  assign tx_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_etx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_etx_serializer
// Purpose  : Directed self-checking bench for etx_serializer. Two instances
//            share the inputs: default MAXBURST=16 and MAXBURST=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_etx_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         tx_access;
  logic [103:0] tx_packet;
  logic         tx_wr_wait;
  logic         tx_rd_wait;
  logic         tx_wait,  tx_frame,  tx_busy;
  logic [7:0]   tx_data;
  logic         tx_wait4, tx_frame4, tx_busy4;
  logic [7:0]   tx_data4;

  always #5 clk = ~clk;

  etx_serializer #(.PW(104), .MAXBURST(16)) dut (
    .clk(clk), .reset(reset), .tx_access(tx_access), .tx_packet(tx_packet),
    .tx_wait(tx_wait), .tx_wr_wait(tx_wr_wait), .tx_rd_wait(tx_rd_wait),
    .tx_frame(tx_frame), .tx_data(tx_data), .tx_busy(tx_busy));

  etx_serializer #(.PW(104), .MAXBURST(4)) dut4 (
    .clk(clk), .reset(reset), .tx_access(tx_access), .tx_packet(tx_packet),
    .tx_wait(tx_wait4), .tx_wr_wait(tx_wr_wait), .tx_rd_wait(tx_rd_wait),
    .tx_frame(tx_frame4), .tx_data(tx_data4), .tx_busy(tx_busy4));

  int n_tests = 0;
  int n_fail  = 0;

  logic [103:0] src_q[$];
  logic         fr_log[$];
  logic [7:0]   dt_log[$];
  logic         wt_log[$];
  logic         bs_log[$];
  int           seg_start[$];
  int           seg_len[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   act_q[$];
  int           idle_bad;

  function automatic logic [103:0] mk(input logic wr, input logic [1:0] dm, input logic [3:0] ctrl,
                                      input logic [31:0] dst, input logic [31:0] data, input logic [31:0] src);
    return {src, data, dst, ctrl, 1'b0, dm, wr};
  endfunction

  function automatic logic [7:0] hdr(input logic wr, input logic [1:0] dm, input logic [3:0] ctrl);
    return {ctrl, dm, wr, 1'b0};
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Presents src_q in order, holding each packet until accepted, and logs
  // one entry per cycle. Entry k is the cycle after clock edge k.
  task automatic run_stream(input bit sel4, input int ncyc, input int wrw_until, input int rdw_from);
    logic w;
    logic acc;
    fr_log.delete(); dt_log.delete(); wt_log.delete(); bs_log.delete();
    for (int c = 0; c < ncyc; c++) begin
      tx_wr_wait = (c < wrw_until);
      tx_rd_wait = (rdw_from >= 0) && (c >= rdw_from);
      if (src_q.size() > 0) begin
        tx_access = 1'b1;
        tx_packet = src_q[0];
      end else begin
        tx_access = 1'b0;
        tx_packet = '0;
      end
      #1;
      w   = sel4 ? tx_wait4 : tx_wait;
      acc = tx_access && (w === 1'b0);
      wt_log.push_back(w);
      @(posedge clk);
      #1;
      if (acc) void'(src_q.pop_front());
      fr_log.push_back(sel4 ? tx_frame4 : tx_frame);
      dt_log.push_back(sel4 ? tx_data4 : tx_data);
      bs_log.push_back(sel4 ? tx_busy4 : tx_busy);
    end
    tx_access  = 1'b0;
    tx_packet  = '0;
    tx_wr_wait = 1'b0;
    tx_rd_wait = 1'b0;
  endtask

  task automatic analyze();
    seg_start.delete(); seg_len.delete(); act_q.delete();
    idle_bad = 0;
    for (int i = 0; i < fr_log.size(); i++) begin
      if (fr_log[i] === 1'b1) begin
        if (i == 0 || fr_log[i-1] !== 1'b1) begin
          seg_start.push_back(i);
          seg_len.push_back(0);
        end
        seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
        act_q.push_back(dt_log[i]);
      end else if (dt_log[i] !== 8'h00) begin
        idle_bad++;
      end
    end
  endtask

  function automatic int first_diff();
    if (act_q.size() != exp_q.size()) return (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < act_q.size(); i++)
      if (act_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; tx_access = 1'b0; tx_packet = '0; tx_wr_wait = 1'b0; tx_rd_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tx_frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b want 0", tx_frame); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_data); end
    n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (tx_frame4 !== 1'b0) begin n_fail++; $display("FAIL reset_frame4: got %b want 0", tx_frame4); end
    tx_packet = mk(1'b1, 2'b10, 4'h0, 32'h0, 32'h0, 32'h0);
    tx_access = 1'b1; tx_wr_wait = 1'b1; #1;
    n_tests++; if (tx_wait !== 1'b1) begin n_fail++; $display("FAIL idle_wait_wr: got %b want 1", tx_wait); end
    tx_wr_wait = 1'b0; #1;
    n_tests++; if (tx_wait !== 1'b0) begin n_fail++; $display("FAIL idle_nowait_wr: got %b want 0", tx_wait); end
    tx_packet = mk(1'b0, 2'b10, 4'h0, 32'h0, 32'h0, 32'h0);
    tx_rd_wait = 1'b1; #1;
    n_tests++; if (tx_wait !== 1'b1) begin n_fail++; $display("FAIL idle_wait_rd: got %b want 1", tx_wait); end
    tx_access = 1'b0; tx_rd_wait = 1'b0; tx_packet = '0;
  endtask

  task automatic test_write();
    int d; int bad;
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h80800000, 32'hDEADBEEF, 32'h0));
    exp_q.delete();
    exp_q.push_back(hdr(1'b1, 2'b10, 4'h0));
    push_word(32'h80800000); push_word(32'hDEADBEEF);
    run_stream(1'b0, 20, 0, -1);
    analyze();
    n_tests++; if (seg_len.size() !== 1 || seg_len[0] !== 9) begin n_fail++; $display("FAIL write_len: got %0d frames len %0d want 1 frame len 9", seg_len.size(), seg_len[0]); end
    n_tests++; if (seg_start[0] !== 0) begin n_fail++; $display("FAIL write_latency: start %0d want 0", seg_start[0]); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL write_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
    bad = 0;
    for (int c = 1; c <= 9; c++) if (wt_log[c] !== 1'b1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL write_wait: %0d frame cycles with wait low, want 0", bad); end
    n_tests++; if (bs_log[8] !== 1'b1 || bs_log[9] !== 1'b0) begin n_fail++; $display("FAIL write_busy: got %b%b want 10", bs_log[8], bs_log[9]); end
    n_tests++; if (idle_bad != 0) begin n_fail++; $display("FAIL write_idle_data: %0d nonzero idle bytes want 0", idle_bad); end
  endtask

  task automatic test_read();
    int d;
    src_q.push_back(mk(1'b0, 2'b10, 4'h0, 32'h81000010, 32'h11223344, 32'h80800020));
    exp_q.delete();
    exp_q.push_back(hdr(1'b0, 2'b10, 4'h0));
    push_word(32'h81000010); push_word(32'h11223344); push_word(32'h80800020);
    run_stream(1'b0, 20, 0, 2);
    analyze();
    n_tests++; if (seg_len.size() !== 1 || seg_len[0] !== 13) begin n_fail++; $display("FAIL read_len: got %0d frames len %0d want 1 frame len 13", seg_len.size(), seg_len[0]); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL read_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
  endtask

  task automatic test_burst();
    int d;
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h100, 32'hA0A1A2A3, 32'h0));
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h104, 32'hB0B1B2B3, 32'h0));
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h108, 32'hC0C1C2C3, 32'h0));
    exp_q.delete();
    exp_q.push_back(8'h0A);
    push_word(32'h100); push_word(32'hA0A1A2A3); push_word(32'hB0B1B2B3); push_word(32'hC0C1C2C3);
    run_stream(1'b0, 30, 0, -1);
    analyze();
    n_tests++; if (seg_len.size() !== 1 || seg_len[0] !== 17) begin n_fail++; $display("FAIL burst_len: got %0d frames len %0d want 1 frame len 17", seg_len.size(), seg_len[0]); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL burst_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
  endtask

  task automatic test_wrap();
    int d;
    src_q.push_back(mk(1'b1, 2'b10, 4'h5, 32'hFFFFFFFC, 32'h01020304, 32'h0));
    src_q.push_back(mk(1'b1, 2'b10, 4'h5, 32'h00000000, 32'h05060708, 32'h0));
    exp_q.delete();
    exp_q.push_back(8'h5A);
    push_word(32'hFFFFFFFC); push_word(32'h01020304); push_word(32'h05060708);
    run_stream(1'b0, 25, 0, -1);
    analyze();
    n_tests++; if (seg_len.size() !== 1 || seg_len[0] !== 13) begin n_fail++; $display("FAIL wrap_len: got %0d frames len %0d want 1 frame len 13", seg_len.size(), seg_len[0]); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL wrap_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
  endtask

  task automatic test_nonchain();
    int d;
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h100, 32'h12345678, 32'h0));
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h10C, 32'h9ABCDEF0, 32'h0));
    exp_q.delete();
    exp_q.push_back(8'h0A); push_word(32'h100); push_word(32'h12345678);
    exp_q.push_back(8'h0A); push_word(32'h10C); push_word(32'h9ABCDEF0);
    run_stream(1'b0, 30, 0, -1);
    analyze();
    n_tests++; if (seg_len.size() !== 2 || seg_len[0] !== 9 || seg_len[1] !== 9) begin n_fail++; $display("FAIL nonchain_frames: got %0d frames len %0d/%0d want 2 frames 9/9", seg_len.size(), seg_len[0], seg_len[1]); end
    n_tests++; if (seg_start[1] - (seg_start[0] + seg_len[0]) !== 1) begin n_fail++; $display("FAIL nonchain_gap: got %0d idle cycles want 1", seg_start[1] - (seg_start[0] + seg_len[0])); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL nonchain_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
  endtask

  task automatic test_pushback();
    int bad;
    src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h300, 32'h0, 32'h0));
    run_stream(1'b0, 16, 3, -1);
    analyze();
    bad = 0;
    for (int c = 0; c < 3; c++) if (fr_log[c] !== 1'b0 || wt_log[c] !== 1'b1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL push_hold: %0d held cycles wrong want 0", bad); end
    n_tests++; if (seg_start[0] !== 3 || seg_len[0] !== 9) begin n_fail++; $display("FAIL push_release: start %0d len %0d want start 3 len 9", seg_start[0], seg_len[0]); end
    src_q.push_back(mk(1'b0, 2'b10, 4'h0, 32'h400, 32'h0, 32'h500));
    run_stream(1'b0, 18, 20, -1);
    analyze();
    n_tests++; if (seg_start[0] !== 0 || seg_len[0] !== 13 || act_q[0] !== 8'h08) begin n_fail++; $display("FAIL push_read: start %0d len %0d hdr %h want 0 13 08", seg_start[0], seg_len[0], act_q[0]); end
  endtask

  task automatic test_maxburst();
    int d;
    logic [31:0] dv;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      dv = {4{8'(i + 1)}};
      src_q.push_back(mk(1'b1, 2'b10, 4'h0, 32'h200 + 32'(4 * i), dv, 32'h0));
      if (i == 0) begin exp_q.push_back(8'h0A); push_word(32'h200); end
      if (i == 4) begin exp_q.push_back(8'h0A); push_word(32'h210); end
      push_word(dv);
    end
    run_stream(1'b1, 45, 0, -1);
    analyze();
    n_tests++; if (seg_len.size() !== 2 || seg_len[0] !== 21 || seg_len[1] !== 13) begin n_fail++; $display("FAIL maxburst_frames: got %0d frames len %0d/%0d want 2 frames 21/13", seg_len.size(), seg_len[0], seg_len[1]); end
    n_tests++; if (seg_start[1] - (seg_start[0] + seg_len[0]) !== 1) begin n_fail++; $display("FAIL maxburst_gap: got %0d idle cycles want 1", seg_start[1] - (seg_start[0] + seg_len[0])); end
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL maxburst_bytes: diff at %0d got %0d bytes want %0d", d, act_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    tx_packet = mk(1'b1, 2'b10, 4'h0, 32'h11223344, 32'h55667788, 32'h0);
    tx_access = 1'b1;
    @(posedge clk); #1;
    tx_access = 1'b0; tx_packet = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++; if (tx_data4 !== 8'h22 || tx_frame4 !== 1'b1) begin n_fail++; $display("FAIL midreset_pos: data %h frame %b want 22 1", tx_data4, tx_frame4); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (tx_frame4 !== 1'b0 || tx_data4 !== 8'h00 || tx_busy4 !== 1'b0) begin n_fail++; $display("FAIL midreset_out: frame %b data %h busy %b want 0 00 0", tx_frame4, tx_data4, tx_busy4); end
    @(posedge clk); #1;
    n_tests++; if (tx_frame4 !== 1'b0 || tx_wait4 !== 1'b0) begin n_fail++; $display("FAIL midreset_dropped: frame %b wait %b want 0 0", tx_frame4, tx_wait4); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_wrap();
    test_nonchain();
    test_pushback();
    test_maxburst();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
